collision_detector: RTL

- Per-pixel collision detector that produces the collision interface consumed by the ball trajectory block: `collision`, `HitEdgeCode`, `diagonalCollision`, `one_sided_collision`, `teleport`, `forced_x` and `forced_y`.
- Watches the ball draw request against the obstacle draw requests while a frame is scanned out, and accumulates which ball edges overlapped.
- Reports the accumulated result as a one-cycle pulse just after the next `startOfFrame`, so the trajectory block updates speeds before its next integration.

---
 rtl/collision_detector.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/collision_detector.sv
// collision_detector: per-pixel ball/obstacle overlap detector for the ball
// trajectory block. While a frame is scanned out it accumulates which obstacle
// kinds the ball overlapped and which ball edges were involved. On the next
// startOfFrame it reports the result as one-clk pulses, one clk after
// startOfFrame.
//
// Optional build macro: COLLISION_COUNT_EN adds hitCount[15:0]. hitCount is a
// saturating count of reports with a wall, diagonal or one-sided hit.
//
// Ports:
//   clk, resetN            clock, asynchronous active-low reset
//   startOfFrame           one-clk pulse marking frame start
//   pixelX, pixelY         current scan position
//   ballTopLeftX/Y         ball sprite origin (signed)
//   ballDR                 ball draw request for the current pixel
//   wallDR, diagDR,
//   oneSidedDR, teleportDR obstacle draw requests for the current pixel
//   collision              wall hit pulse (suppressed during cooldown)
//   HitEdgeCode            ball edges hit: bit0 bottom, bit1 right,
//                          bit2 top, bit3 left
//   diagonalCollision      diagonal hit pulse (suppressed during cooldown)
//   one_sided_collision    one-sided gate hit pulse (never suppressed)
//   teleport               teleport pad entry pulse
//   forced_x, forced_y     first teleport-overlap pixel of the reported frame
//   hitCount               (COLLISION_COUNT_EN only) saturating hit counter
module collision_detector #(
    parameter int BALL_W          = 32,
    parameter int BALL_H          = 32,
    parameter int EDGE_W          = 4,
    parameter int COOLDOWN_FRAMES = 2
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic        [10:0] pixelX,
    input  logic        [10:0] pixelY,
    input  logic signed [10:0] ballTopLeftX,
    input  logic signed [10:0] ballTopLeftY,
    input  logic               ballDR,
    input  logic               wallDR,
    input  logic               diagDR,
    input  logic               oneSidedDR,
    input  logic               teleportDR,
    output logic               collision,
    output logic        [3:0]  HitEdgeCode,
    output logic               diagonalCollision,
    output logic               one_sided_collision,
    output logic               teleport,
    output logic        [10:0] forced_x,
    output logic        [10:0] forced_y
`ifdef COLLISION_COUNT_EN
    ,
    output logic        [15:0] hitCount
`endif
);

    localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    localparam logic signed [11:0] EDGE_LO  = 12'(EDGE_W);
    localparam logic signed [11:0] RIGHT_HI = 12'(BALL_W - EDGE_W);
    localparam logic signed [11:0] BOT_HI   = 12'(BALL_H - EDGE_W);

    typedef enum logic {ACCUM, REPORT} state_t;

    state_t            state;
    logic              acc_wall, acc_diag, acc_one, acc_tele;
    logic [3:0]        acc_edge;
    logic [10:0]       tele_x, tele_y;
    logic              prev_tele;
    logic [CD_W-1:0]   cooldown;

    // Pixel offset inside the ball sprite. pixelX is unsigned and the ball
    // origin is signed, so both are widened to 12-bit signed.
    logic signed [11:0] off_x, off_y;
    assign off_x = $signed({1'b0, pixelX}) - $signed({ballTopLeftX[10], ballTopLeftX});
    assign off_y = $signed({1'b0, pixelY}) - $signed({ballTopLeftY[10], ballTopLeftY});

    logic [3:0] edge_bits;
    assign edge_bits = {(off_x <  EDGE_LO),     // left
                        (off_y <  EDGE_LO),     // top
                        (off_x >= RIGHT_HI),    // right
                        (off_y >= BOT_HI)};     // bottom

    logic       pix_wall, pix_diag, pix_one, pix_tele;
    logic [3:0] pix_edge;
    assign pix_wall = ballDR & wallDR;
    assign pix_diag = ballDR & diagDR;
    assign pix_one  = ballDR & oneSidedDR;
    assign pix_tele = ballDR & teleportDR;
    assign pix_edge = (ballDR & (wallDR | diagDR)) ? edge_bits : 4'b0000;

    // Report decision, taken from the accumulators at the startOfFrame edge.
    // The output registers act as the snapshot of the finished frame.
    logic cd_zero, rep_coll, rep_diag;
    assign cd_zero  = (cooldown == '0);
    assign rep_coll = acc_wall & cd_zero;
    assign rep_diag = acc_diag & cd_zero;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state               <= ACCUM;
            acc_wall            <= 1'b0;
            acc_diag            <= 1'b0;
            acc_one             <= 1'b0;
            acc_tele            <= 1'b0;
            acc_edge            <= 4'b0000;
            tele_x              <= 11'd0;
            tele_y              <= 11'd0;
            prev_tele           <= 1'b0;
            cooldown            <= '0;
            collision           <= 1'b0;
            HitEdgeCode         <= 4'b0000;
            diagonalCollision   <= 1'b0;
            one_sided_collision <= 1'b0;
            teleport            <= 1'b0;
            forced_x            <= 11'd0;
            forced_y            <= 11'd0;
`ifdef COLLISION_COUNT_EN
            hitCount            <= 16'd0;
`endif
        end else if (startOfFrame) begin
            // Frame boundary: publish the finished frame. The current pixel
            // seeds the fresh accumulators because it belongs to the new frame.
            // A startOfFrame seen while in REPORT takes the same path.
            state               <= REPORT;
            collision           <= rep_coll;
            diagonalCollision   <= rep_diag;
            HitEdgeCode         <= (rep_coll | rep_diag) ? acc_edge : 4'b0000;
            one_sided_collision <= acc_one;
            teleport            <= acc_tele & ~prev_tele;
            prev_tele           <= acc_tele;
            forced_x            <= tele_x;
            forced_y            <= tele_y;

            if (rep_coll | rep_diag)
                cooldown <= CD_W'(COOLDOWN_FRAMES);
            else if (!cd_zero)
                cooldown <= cooldown - CD_W'(1);

`ifdef COLLISION_COUNT_EN
            if ((rep_coll | rep_diag | acc_one) && (hitCount != 16'hFFFF))
                hitCount <= hitCount + 16'd1;
`endif

            acc_wall <= pix_wall;
            acc_diag <= pix_diag;
            acc_one  <= pix_one;
            acc_tele <= pix_tele;
            acc_edge <= pix_edge;
            if (pix_tele) begin
                tele_x <= pixelX;
                tele_y <= pixelY;
            end
        end else if (state == REPORT) begin
            // Pulses last exactly one clk. forced_x/forced_y hold their value.
            state               <= ACCUM;
            collision           <= 1'b0;
            diagonalCollision   <= 1'b0;
            HitEdgeCode         <= 4'b0000;
            one_sided_collision <= 1'b0;
            teleport            <= 1'b0;
        end else begin
            acc_wall <= acc_wall | pix_wall;
            acc_diag <= acc_diag | pix_diag;
            acc_one  <= acc_one  | pix_one;
            acc_tele <= acc_tele | pix_tele;
            acc_edge <= acc_edge | pix_edge;
            // Only the first teleport overlap of the frame is kept.
            if (pix_tele && !acc_tele) begin
                tele_x <= pixelX;
                tele_y <= pixelY;
            end
        end
    end

endmodule
